// File: rtl/spi_write_snooper.sv
// Passive decoder for the registered SPI RAM bus: tracks cmd/addr/data framing and
// captures CPU writes into the word-aligned LED register as a 32-bit word.
module spi_write_snooper #(
   parameter logic [23:0] MATCH_ADDR = 24'hFFFFFC,
   parameter logic [7:0]  CMD_WRITE  = 8'h02,
   parameter logic [7:0]  CMD_READ   = 8'h03
) (
   input  logic        cpu_clk,
   input  logic        rstn,
   input  logic        spi_select,
   input  logic        spi_mosi,
   output logic [31:0] led_word,
   output logic        word_valid,
   output logic        busy,
   output logic        cmd_err,
   output logic [15:0] txn_count
);

   typedef enum logic [2:0] {SYNC, IDLE, CMD, ADDR, DATA, SKIP} state_t;

   state_t      state, state_nxt;
   logic [4:0]  bit_cnt;
   logic [23:0] sr;
   logic [23:0] byte_addr;
   logic        is_write;
   logic        hit_seen;

   logic [7:0]  cmd_full;
   logic        cmd_ok;
   logic        byte_done;
   logic        hit;

   assign cmd_full  = {sr[6:0], spi_mosi};
   assign cmd_ok    = (cmd_full == CMD_WRITE) || (cmd_full == CMD_READ);
   assign byte_done = (state == DATA) && !spi_select && (bit_cnt[2:0] == 3'd7);
   assign hit       = byte_done && is_write && (byte_addr[23:2] == MATCH_ADDR[23:2]);
   assign busy      = (state != IDLE) && (state != SYNC);

   // Bit 7 of the command is sampled in IDLE, so CMD only sees bits 6..0.
   always_comb begin
      state_nxt = state;
      case (state)
         SYNC: if (spi_select) state_nxt = IDLE;
         IDLE: if (!spi_select) state_nxt = CMD;
         CMD: begin
            if (spi_select)          state_nxt = IDLE;
            else if (bit_cnt == 5'd6) state_nxt = cmd_ok ? ADDR : SKIP;
         end
         ADDR: begin
            if (spi_select)           state_nxt = IDLE;
            else if (bit_cnt == 5'd23) state_nxt = DATA;
         end
         DATA, SKIP: if (spi_select) state_nxt = IDLE;
         default: state_nxt = SYNC;
      endcase
   end

   always_ff @(posedge cpu_clk) begin
      if (!rstn) begin
         state      <= SYNC;
         bit_cnt    <= '0;
         sr         <= '0;
         byte_addr  <= '0;
         is_write   <= 1'b0;
         hit_seen   <= 1'b0;
         led_word   <= '0;
         word_valid <= 1'b0;
         cmd_err    <= 1'b0;
         txn_count  <= '0;
      end else begin
         state      <= state_nxt;
         sr         <= {sr[22:0], spi_mosi};
         word_valid <= 1'b0;
         cmd_err    <= 1'b0;
         if (state_nxt != state || spi_select) bit_cnt <= '0;
         else                                   bit_cnt <= bit_cnt + 5'd1;

         if (state == CMD && state_nxt == ADDR) is_write <= (cmd_full == CMD_WRITE);
         if (state == CMD && state_nxt == SKIP) cmd_err <= 1'b1;
         if (state == ADDR && state_nxt == DATA) begin
            byte_addr <= {sr[22:0], spi_mosi};
            hit_seen  <= 1'b0;
         end

         if (byte_done) begin
            byte_addr <= byte_addr + 24'd1;
            if (hit) begin
               led_word[{byte_addr[1:0], 3'b000} +: 8] <= {sr[6:0], spi_mosi};
               hit_seen <= 1'b1;
            end
         end

         // Deselect ends the transaction; a partial data byte is simply dropped.
         if (state == DATA && spi_select) begin
            txn_count  <= txn_count + 16'd1;
            word_valid <= hit_seen;
            hit_seen   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_spi_write_snooper.sv
// Scoreboard bench: transaction-level model pushes expected pulses, monitor pops them.
module tb_spi_write_snooper;

   logic        cpu_clk = 1'b0;
   logic        rstn = 1'b0;
   logic        spi_select = 1'b1;
   logic        spi_mosi = 1'b0;
   logic [31:0] led_word;
   logic        word_valid, busy, cmd_err;
   logic [15:0] txn_count;

   spi_write_snooper dut (
      .cpu_clk(cpu_clk), .rstn(rstn), .spi_select(spi_select), .spi_mosi(spi_mosi),
      .led_word(led_word), .word_valid(word_valid), .busy(busy), .cmd_err(cmd_err),
      .txn_count(txn_count)
   );

   always #5 cpu_clk = ~cpu_clk;

   typedef struct {int cyc; logic [31:0] word;} exp_t;
   exp_t wv_q[$];
   int   ce_q[$];
   int   cyc = 0;
   int   n_vec = 0, n_err = 0;
   logic [31:0] m_word = '0;
   logic [15:0] m_cnt = '0;

   always @(posedge cpu_clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(negedge cpu_clk) begin
      if (word_valid) begin
         if (wv_q.size() == 0) chk("wv_spurious", 32'd1, 32'd0);
         else begin
            exp_t e;
            e = wv_q.pop_front();
            chk("wv_cycle", cyc, e.cyc);
            chk("wv_led_word", led_word, e.word);
         end
      end
      if (cmd_err) begin
         if (ce_q.size() == 0) chk("cmd_err_spurious", 32'd1, 32'd0);
         else chk("cmd_err_cycle", cyc, ce_q.pop_front());
      end
   end

   task automatic do_reset();
      @(negedge cpu_clk);
      rstn = 1'b0; spi_select = 1'b1;
      m_word = '0; m_cnt = '0;
      @(negedge cpu_clk);
      rstn = 1'b1;
   endtask

   // Sends cmd + 24-bit addr + nbytes of d (byte0 in d[7:0]) + extra MSB bits of the next byte.
   task automatic send(input logic [7:0] c, input logic [23:0] a, input int nbytes,
                       input logic [63:0] d, input int extra, input int gap);
      logic   bq[$];
      logic [23:0] ba;
      logic   hit;
      bit     valid;
      valid = (c == 8'h02) || (c == 8'h03);
      for (int i = 7; i >= 0; i--) bq.push_back(c[i]);
      for (int i = 23; i >= 0; i--) bq.push_back(a[i]);
      for (int k = 0; k < nbytes; k++)
         for (int i = 7; i >= 0; i--) bq.push_back(d[8*k+i]);
      for (int i = 0; i < extra; i++) bq.push_back(d[8*nbytes+7-i]);
      ba = a; hit = 1'b0;
      if (valid) begin
         m_cnt++;
         for (int k = 0; k < nbytes; k++) begin
            if (c == 8'h02 && ba[23:2] == 22'h3FFFFF) begin
               m_word[{ba[1:0], 3'b000} +: 8] = d[8*k +: 8];
               hit = 1'b1;
            end
            ba = ba + 24'd1;
         end
      end
      foreach (bq[i]) begin
         @(negedge cpu_clk);
         if (i == 7 && !valid) ce_q.push_back(cyc + 1);
         spi_select = 1'b0; spi_mosi = bq[i];
      end
      @(negedge cpu_clk);
      spi_select = 1'b1;
      if (hit) wv_q.push_back('{cyc + 1, m_word});
      for (int i = 1; i < gap; i++) @(negedge cpu_clk);
   endtask

   task automatic end_chk(input string tag);
      repeat (3) @(negedge cpu_clk);
      chk({tag, "_led_word"}, led_word, m_word);
      chk({tag, "_txn_count"}, {16'd0, txn_count}, {16'd0, m_cnt});
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_wv_pending"}, wv_q.size(), 32'd0);
      chk({tag, "_ce_pending"}, ce_q.size(), 32'd0);
   endtask

   initial begin
      repeat (3) @(negedge cpu_clk);
      rstn = 1'b1;
      @(negedge cpu_clk);
      chk("rst_led_word", led_word, 32'd0);
      chk("rst_txn_count", {16'd0, txn_count}, 32'd0);
      chk("rst_flags", {29'd0, word_valid, busy, cmd_err}, 32'd0);

      // full word write, then a read over it, an invalid cmd and a wrapping write
      send(8'h02, 24'hFFFFFC, 4, 64'h44332211, 0, 2);
      end_chk("wr_full");
      send(8'h03, 24'hFFFFFC, 4, 64'hFFFFFFFF, 0, 1);
      send(8'h9F, 24'h000000, 2, 64'hFFFF, 0, 1);
      send(8'h02, 24'hFFFFFD, 4, 64'hDDCCBBAA, 0, 1);
      end_chk("rd_err_wrap");

      do_reset();
      send(8'h02, 24'hFFFFFE, 1, 64'hAA, 0, 1);
      send(8'h02, 24'h000000, 1, 64'h55, 0, 1);
      end_chk("lane2_nomatch");
      send(8'h02, 24'hFFFFF8, 8, 64'h8877665544332211, 0, 3);
      end_chk("run_into_word");

      do_reset();
      send(8'h02, 24'hFFFFFC, 1, 64'h2011, 4, 1);
      end_chk("partial_byte");
      send(8'h02, 24'hFFFFFC, 0, 64'h0, 0, 1);
      end_chk("zero_bytes");

      // reset in the middle of an address with select held low
      begin
         logic [19:0] pre;
         logic [15:0] post;
         pre = 20'h02FFF; post = 16'h02FF;
         for (int i = 19; i >= 0; i--) begin
            @(negedge cpu_clk); spi_select = 1'b0; spi_mosi = pre[i];
         end
         @(negedge cpu_clk); rstn = 1'b0; spi_mosi = 1'b1;
         m_word = '0; m_cnt = '0;
         @(negedge cpu_clk); rstn = 1'b1;
         chk("midrst_led_word", led_word, 32'd0);
         chk("midrst_txn_count", {16'd0, txn_count}, 32'd0);
         for (int i = 15; i >= 0; i--) begin
            @(negedge cpu_clk); spi_mosi = post[i];
         end
         @(negedge cpu_clk);
         chk("midrst_busy", {31'd0, busy}, 32'd0);
         chk("midrst_hold_count", {16'd0, txn_count}, 32'd0);
         spi_select = 1'b1;
      end
      send(8'h02, 24'hFFFFFC, 1, 64'h11, 0, 1);
      end_chk("after_midrst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
